// File: rtl/byte_packer_pkg.sv
// rtl/byte_packer_pkg.sv - shared state type and default sizing for the byte packer
package byte_packer_pkg;

  localparam int DEFAULT_BYTES_PER_WORD = 4;
  localparam int DEFAULT_FIFO_DEPTH     = 2;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FILL       = 2'd1,
    ST_FLUSH_WAIT = 2'd2
  } packer_state_e;

endpackage

// File: rtl/byte_packer_fifo.sv
// rtl/byte_packer_fifo.sv - word FIFO with valid/ready on both sides and registered storage
module byte_packer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_OCC = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      occ_q;
  logic             push, pop;

  assign full      = (occ_q == FULL_OCC);
  assign empty     = (occ_q == '0);
  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr_q];
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign in_ready  = !full || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        occ_q <= occ_q + 1'b1;
      end else if (pop && !push) begin
        occ_q <= occ_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs a byte stream into words, with flush of partial words
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter int BYTES_PER_WORD = DEFAULT_BYTES_PER_WORD,
  parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  in,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        flush,
  output logic [8*BYTES_PER_WORD-1:0] out_data,
  output logic [BYTES_PER_WORD-1:0]   out_keep,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy
);

  localparam int DW = 8 * BYTES_PER_WORD;
  localparam int CW = $clog2(BYTES_PER_WORD);
  localparam logic [CW-1:0] LAST_LANE = CW'(BYTES_PER_WORD - 1);

  packer_state_e              state_q, state_d;
  logic [CW-1:0]              count_q, count_d;
  logic [DW-1:0]              data_q, data_d;
  logic [CW:0]                fill_n;
  logic [DW-1:0]              lanes;
  logic [BYTES_PER_WORD-1:0]  push_keep;
  logic                       accept, push_req;
  logic                       fifo_in_ready, fifo_full, fifo_empty;

  // Built only from registered state so upstream never sees out_ready ripple through.
  assign in_ready = (state_q != ST_FLUSH_WAIT) && !((count_q == LAST_LANE) && fifo_full);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;

  always_comb begin
    fill_n = {1'b0, count_q} + (CW + 1)'(accept);
    for (int l = 0; l < BYTES_PER_WORD; l++) begin
      lanes[l*8 +: 8] = (accept && (count_q == CW'(l))) ? in : data_q[l*8 +: 8];
      push_keep[l]    = ((CW + 1)'(l) < fill_n);
    end

    push_req = 1'b0;
    state_d  = state_q;
    count_d  = count_q;
    data_d   = data_q;

    case (state_q)
      ST_FLUSH_WAIT: begin
        if (!fifo_full) begin
          push_req = 1'b1;
          state_d  = ST_IDLE;
          count_d  = '0;
          data_d   = '0;
        end
      end
      default: begin
        if (accept && (count_q == LAST_LANE)) begin
          // Completing byte wins over a coincident flush: one full word only.
          push_req = 1'b1;
          state_d  = ST_IDLE;
          count_d  = '0;
          data_d   = '0;
        end else if (flush && (fill_n != '0)) begin
          if (!fifo_full) begin
            push_req = 1'b1;
            state_d  = ST_IDLE;
            count_d  = '0;
            data_d   = '0;
          end else begin
            state_d = ST_FLUSH_WAIT;
            count_d = fill_n[CW-1:0];
            data_d  = lanes;
          end
        end else begin
          state_d = (fill_n == '0) ? ST_IDLE : ST_FILL;
          count_d = fill_n[CW-1:0];
          data_d  = lanes;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  byte_packer_fifo #(
    .WIDTH (DW + BYTES_PER_WORD),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_data   ({lanes, push_keep}),
    .in_valid  (push_req && fifo_in_ready),
    .in_ready  (fifo_in_ready),
    .out_data  ({out_data, out_keep}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_byte_packer.sv
// tb/tb_byte_packer.sv - self-checking bench for byte_packer
module tb_byte_packer;

  localparam int BPW   = 4;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic        in_ready, out_valid, busy;
  logic [7:0]  in_byte;
  logic [31:0] out_data;
  logic [3:0]  out_keep;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
  } word_t;

  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic        f;
    logic        r;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_d;
    logic [3:0]  e_k;
    logic        e_busy;
  } vec_t;

  word_t      fq[$];
  logic [7:0] part[$];
  bit         pend = 1'b0;
  word_t      popped[$];

  always #5 clk = ~clk;

  byte_packer #(
    .BYTES_PER_WORD (BPW),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic bit m_in_ready();
    return !pend && !((part.size() == BPW - 1) && (fq.size() == DEPTH));
  endfunction

  function automatic word_t part_word();
    word_t w;
    w = '0;
    foreach (part[i]) begin
      w.d[i*8 +: 8] = part[i];
      w.k[i]        = 1'b1;
    end
    return w;
  endfunction

  task automatic cycle(input logic v, input logic [7:0] b, input logic f, input logic r,
                       input logic rst, output logic s_ir, output logic s_ov,
                       output logic [31:0] s_d, output logic [3:0] s_k, output logic s_busy);
    bit acc, full, pop;
    reset = rst; in_valid = v; in_byte = b; flush = f; out_ready = r;
    @(negedge clk);
    s_ir = in_ready; s_ov = out_valid; s_d = out_data; s_k = out_keep; s_busy = busy;
    chk("model_in_ready", 64'(in_ready), 64'(m_in_ready()));
    chk("model_out_valid", 64'(out_valid), 64'(fq.size() > 0));
    chk("model_busy", 64'(busy), 64'((part.size() > 0) || pend || (fq.size() > 0)));
    if (fq.size() > 0) chk("model_word", 64'({out_data, out_keep}), 64'(fq[0]));
    if (out_valid && out_ready && !rst) popped.push_back({out_data, out_keep});
    acc  = v && m_in_ready();
    full = (fq.size() == DEPTH);
    pop  = (fq.size() > 0) && r;
    if (rst) begin
      part.delete(); fq.delete(); pend = 1'b0;
    end else begin
      if (pend) begin
        if (!full) begin fq.push_back(part_word()); part.delete(); pend = 1'b0; end
      end else begin
        if (acc) part.push_back(b);
        if (part.size() == BPW) begin
          fq.push_back(part_word()); part.delete();
        end else if (f && (part.size() > 0)) begin
          if (!full) begin fq.push_back(part_word()); part.delete(); end
          else pend = 1'b1;
        end
      end
      if (pop) void'(fq.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic v, input logic [7:0] b, input logic f, input logic r);
    logic a0, a1, a4; logic [31:0] a2; logic [3:0] a3;
    cycle(v, b, f, r, 1'b0, a0, a1, a2, a3, a4);
  endtask

  task automatic rst_tick();
    logic a0, a1, a4; logic [31:0] a2; logic [3:0] a3;
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, a0, a1, a2, a3, a4);
  endtask

  function automatic vec_t mk(logic v, logic [7:0] b, logic f, logic r, logic e_ir,
                              logic e_ov, logic [31:0] e_d, logic [3:0] e_k, logic e_busy);
    vec_t x;
    x.v = v; x.b = b; x.f = f; x.r = r; x.e_ir = e_ir;
    x.e_ov = e_ov; x.e_d = e_d; x.e_k = e_k; x.e_busy = e_busy;
    return x;
  endfunction

  vec_t vt[17];

  initial begin
    logic s_ir, s_ov, s_busy;
    logic [31:0] s_d;
    logic [3:0]  s_k;
    bit          acc_now, got;
    word_t       exp3[3];

    vt[0]  = mk(1, 8'h11, 0, 1, 1, 0, 32'h0,        4'h0, 0);
    vt[1]  = mk(1, 8'h22, 0, 1, 1, 0, 32'h0,        4'h0, 1);
    vt[2]  = mk(1, 8'h33, 0, 1, 1, 0, 32'h0,        4'h0, 1);
    vt[3]  = mk(1, 8'h44, 0, 1, 1, 0, 32'h0,        4'h0, 1);
    vt[4]  = mk(0, 8'h00, 0, 1, 1, 1, 32'h44332211, 4'hF, 1);
    vt[5]  = mk(1, 8'hAA, 0, 1, 1, 0, 32'h0,        4'h0, 0);
    vt[6]  = mk(1, 8'hBB, 0, 1, 1, 0, 32'h0,        4'h0, 1);
    vt[7]  = mk(0, 8'h00, 1, 1, 1, 0, 32'h0,        4'h0, 1);
    vt[8]  = mk(0, 8'h00, 0, 1, 1, 1, 32'h0000BBAA, 4'h3, 1);
    vt[9]  = mk(0, 8'h00, 1, 1, 1, 0, 32'h0,        4'h0, 0);
    vt[10] = mk(0, 8'h00, 0, 1, 1, 0, 32'h0,        4'h0, 0);
    vt[11] = mk(1, 8'h01, 0, 1, 1, 0, 32'h0,        4'h0, 0);
    vt[12] = mk(1, 8'h02, 0, 1, 1, 0, 32'h0,        4'h0, 1);
    vt[13] = mk(1, 8'h03, 0, 1, 1, 0, 32'h0,        4'h0, 1);
    vt[14] = mk(1, 8'h04, 1, 1, 1, 0, 32'h0,        4'h0, 1);
    vt[15] = mk(0, 8'h00, 0, 1, 1, 1, 32'h04030201, 4'hF, 1);
    vt[16] = mk(0, 8'h00, 0, 1, 1, 0, 32'h0,        4'h0, 0);

    reset = 1'b1; in_valid = 1'b0; in_byte = 8'h00; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'(1'b1));
    chk("reset_out_valid", 64'(out_valid), 64'(1'b0));
    chk("reset_out_data", 64'(out_data), 64'(32'h0));
    chk("reset_out_keep", 64'(out_keep), 64'(4'h0));
    chk("reset_busy", 64'(busy), 64'(1'b0));

    for (int i = 0; i < 17; i++) begin
      cycle(vt[i].v, vt[i].b, vt[i].f, vt[i].r, 1'b0, s_ir, s_ov, s_d, s_k, s_busy);
      chk($sformatf("vec%0d_in_ready", i), 64'(s_ir), 64'(vt[i].e_ir));
      chk($sformatf("vec%0d_out_valid", i), 64'(s_ov), 64'(vt[i].e_ov));
      chk($sformatf("vec%0d_busy", i), 64'(s_busy), 64'(vt[i].e_busy));
      if (vt[i].e_ov) chk($sformatf("vec%0d_word", i), 64'({s_d, s_k}), 64'({vt[i].e_d, vt[i].e_k}));
    end

    // Backpressure: two words queue, third word stalls on its last byte.
    popped.delete();
    for (int i = 1; i <= 11; i++) tick(1'b1, 8'(i), 1'b0, 1'b0);
    chk("bp_in_ready_low", 64'(in_ready), 64'(1'b0));
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      acc_now = m_in_ready();
      tick(1'b1, 8'h0C, 1'b0, 1'b1);
      got = acc_now;
    end
    chk("bp_byte12_accepted", 64'(got), 64'(1'b1));
    for (int t = 0; t < 8; t++) tick(1'b0, 8'h00, 1'b0, 1'b1);
    exp3[0] = '{d: 32'h04030201, k: 4'hF};
    exp3[1] = '{d: 32'h08070605, k: 4'hF};
    exp3[2] = '{d: 32'h0C0B0A09, k: 4'hF};
    chk("bp_word_count", 64'(popped.size()), 64'(3));
    for (int i = 0; i < 3; i++) begin
      if (i < popped.size()) chk($sformatf("bp_word%0d", i), 64'(popped[i]), 64'(exp3[i]));
    end

    // Flush while the FIFO is full parks until a slot opens.
    popped.delete();
    for (int i = 0; i < 8; i++) tick(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
    tick(1'b1, 8'h5A, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fw_in_ready_low", 64'(in_ready), 64'(1'b0));
    chk("fw_busy", 64'(busy), 64'(1'b1));
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    chk("fw_in_ready_back", 64'(in_ready), 64'(1'b1));
    for (int t = 0; t < 6; t++) tick(1'b0, 8'h00, 1'b0, 1'b1);
    chk("fw_word_count", 64'(popped.size()), 64'(3));
    if (popped.size() == 3) chk("fw_partial_word", 64'(popped[2]), 64'({32'h0000005A, 4'h1}));

    // Reset mid-word drops the partial bytes.
    popped.delete();
    for (int i = 0; i < 3; i++) tick(1'b1, 8'(8'hE0 + i), 1'b0, 1'b1);
    rst_tick();
    for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'h61 + i), 1'b0, 1'b1);
    for (int t = 0; t < 4; t++) tick(1'b0, 8'h00, 1'b0, 1'b1);
    chk("rst_word_count", 64'(popped.size()), 64'(1));
    if (popped.size() == 1) chk("rst_clean_word", 64'(popped[0]), 64'({32'h64636261, 4'hF}));

    for (int t = 0; t < 800; t++) begin
      logic rv, rf, rr, rs;
      logic [7:0] rb;
      logic a0, a1, a4; logic [31:0] a2; logic [3:0] a3;
      rv = ($urandom_range(0, 3) != 0);
      rb = 8'($urandom);
      rf = ($urandom_range(0, 7) == 0);
      rr = ($urandom_range(0, 2) != 0);
      rs = ($urandom_range(0, 199) == 0);
      cycle(rv, rb, rf, rr, rs, a0, a1, a2, a3, a4);
    end
    for (int t = 0; t < 10; t++) tick(1'b0, 8'h00, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_packer.md
BYTE_PACKER -- requirements
Module: byte_packer

Interface
REQ-001 SHALL have parameter BYTES_PER_WORD, default 4, bytes packed per output word (legal 2..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, output word FIFO entries (legal 2..8, power of two).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in  input  8  byte from the upstream interface.
REQ-006 SHALL have port in_valid  input  1  byte on in is valid.
REQ-007 SHALL have port in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-008 SHALL have port flush  input  1  single-cycle pulse, emit the partial word.
REQ-009 SHALL have port out_data  output  8*BYTES_PER_WORD  packed word, first byte in bits [7:0].
REQ-010 SHALL have port out_keep  output  BYTES_PER_WORD  per-byte valid mask of out_data.
REQ-011 SHALL have port out_valid / out_ready  output / input  1 / 1  word transferred when both high.
REQ-012 SHALL have port busy  output  1  high when assembly is partial, a flush is pending, or the FIFO is non-empty.

Function
REQ-013 SHALL implement states IDLE (count=0), FILL (1..BYTES_PER_WORD-1 bytes held) and FLUSH_WAIT (flush pending, FIFO full).
REQ-014 SHALL store each accepted byte at lane count, then increment count.
REQ-015 SHALL push {data, all-ones keep} to the FIFO on the edge accepting byte BYTES_PER_WORD, returning count to 0 (IDLE).
REQ-016 SHALL drive in_ready = 0 when count==BYTES_PER_WORD-1 and the FIFO is full, or in FLUSH_WAIT; otherwise 1; in_ready SHALL NOT depend combinationally on out_ready.
REQ-017 SHALL, on flush in FILL with FIFO not full, push the partial word with keep bits [count-1:0] set and unused lanes zero, then go to IDLE.
REQ-018 SHALL, on flush in FILL with FIFO full, enter FLUSH_WAIT and push on the first cycle the FIFO is not full.
REQ-019 SHALL ignore flush in IDLE (no push) and a repeated flush in FLUSH_WAIT.
REQ-020 SHALL, on flush coinciding with an accepted byte, include that byte; if it completes the word, exactly one full word is pushed.
REQ-021 SHALL permit a FIFO push and pop in the same cycle when full, with no loss.
REQ-022 SHALL give one cycle latency from the completing byte or flush to out_valid (FIFO registered output).
REQ-023 SHALL hold out_data/out_keep stable while out_valid && !out_ready.
REQ-024 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH with a separate occupancy count for full/empty.

Reset
REQ-025 SHALL, while reset is high at a clock edge, set count=0, state=IDLE, FIFO empty, out_valid=0, out_data=0, out_keep=0, busy=0, in_ready=1.
REQ-026 SHALL discard any partial word and pending flush on reset mid-operation, without emitting them.

Structure
REQ-027 SHALL take the state enum and the BYTES_PER_WORD/FIFO_DEPTH defaults from package byte_packer_pkg.
REQ-028 SHALL implement the FIFO as sub-module byte_packer_fifo (parameterised width/depth, valid/ready both sides).

Verification
REQ-029 SHALL cover: bytes 0x11,0x22,0x33,0x44 back-to-back, out_ready=1 -> out_data=0x44332211, keep=0xF, one cycle after 4th byte.
REQ-030 SHALL cover: bytes 0xAA,0xBB then flush -> out_data=0x0000BBAA, keep=0x3; flush in IDLE -> no word.
REQ-031 SHALL cover: out_ready=0, 12 bytes sent -> two words queued, in_ready drops at 4th byte of third word; release -> three words in order, none lost.
REQ-032 SHALL cover: FIFO full, one byte held, flush -> FLUSH_WAIT, in_ready=0; one pop -> partial word keep=0x1 pushed, in_ready=1.
REQ-033 SHALL cover: reset asserted after 3 bytes -> no output, next 4 bytes form a clean full word.
REQ-034 SHALL cover: flush coincident with 4th byte -> single word keep=0xF, no extra word.
